// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per cycle.
// A start in IDLE captures the operands. CALC runs WIDTH shift/subtract
// iterations, FIX registers the results, and DONE pulses done for one cycle.
// A zero divisor bypasses CALC and reports div_by_zero.
// Optional build macro DIV_SIGNED_EN: two's-complement operands with
// truncating division (quotient toward zero, remainder takes dividend sign).
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   part_rem;   // partial remainder, WIDTH+1 bits
    logic [WIDTH-1:0] dvd_reg;    // dividend magnitude, becomes the quotient
    logic [WIDTH-1:0] dvs_reg;    // divisor magnitude
    logic [WIDTH+1:0] shifted;    // {part_rem, next dividend bit}
    logic [WIDTH+1:0] trial;      // shifted minus divisor; MSB set means negative

`ifdef DIV_SIGNED_EN
    logic neg_quot;
    logic neg_rem;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // Magnitude of a two's-complement value; the most-negative value maps to
    // its own bit pattern, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? negate(v) : v;
    endfunction
`endif

    assign shifted = {part_rem, dvd_reg[WIDTH-1]};
    assign trial   = shifted - {2'b00, dvs_reg};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == LAST_ITER) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, shift/subtract iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            part_rem    <= '0;
            dvd_reg     <= '0;
            dvs_reg     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quot    <= 1'b0;
            neg_rem     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            part_rem <= '0;
                            count    <= '0;
`ifdef DIV_SIGNED_EN
                            dvd_reg  <= magnitude(dividend);
                            dvs_reg  <= magnitude(divisor);
                            neg_quot <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            neg_rem  <= dividend[WIDTH-1];
`else
                            dvd_reg  <= dividend;
                            dvs_reg  <= divisor;
`endif
                        end
                    end
                end
                CALC: begin
                    // Keep the difference when it is non-negative, otherwise
                    // restore the shifted value; the sign decides the quotient bit.
                    part_rem <= trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
                    dvd_reg  <= {dvd_reg[WIDTH-2:0], ~trial[WIDTH+1]};
                    count    <= count + CNT_W'(1);
                end
                FIX: begin
`ifdef DIV_SIGNED_EN
                    quotient  <= neg_quot ? negate(dvd_reg) : dvd_reg;
                    remainder <= neg_rem ? negate(part_rem[WIDTH-1:0])
                                         : part_rem[WIDTH-1:0];
`else
                    quotient  <= dvd_reg;
                    remainder <= part_rem[WIDTH-1:0];
`endif
                    div_by_zero <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=8): stimulus pushes expected
// results with their expected done cycle; a monitor pops on every done.
module tb_seq_divider;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Posedge counter; at a negedge it holds the index of the last posedge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             z;
        int               at;
        string            tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done at cycle %0d with nothing outstanding", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, "_quotient"}, 32'(quotient), 32'(e.q));
                chk({e.tag, "_remainder"}, 32'(remainder), 32'(e.r));
                chk({e.tag, "_div_by_zero"}, 32'(div_by_zero), 32'(e.z));
                chk({e.tag, "_done_cycle"}, 32'(cyc), 32'(e.at));
            end
        end
    end

    // Done follows the accepting edge by WIDTH+1 edges, or by none for /0.
    function automatic int done_at(input int acc, input logic z);
        return z ? acc : acc + WIDTH + 1;
    endfunction

    // Issue one divide from a negedge; the next posedge must accept it.
    task automatic launch(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r, input logic z);
        int acc;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        acc      = cyc + 1;
        sb.push_back('{q, r, z, done_at(acc, z), tag});
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'hA5;
        divisor  = 8'h5A;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    // Wait for all outstanding results, bounded.
    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d results outstanding, expected 0", tag, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [WIDTH-1:0] q_200_9;
        logic [WIDTH-1:0] r_200_9;
`ifdef DIV_SIGNED_EN
        q_200_9 = 8'hFA;   // -56 / 9 = -6 rem -2
        r_200_9 = 8'hFE;
`else
        q_200_9 = 8'd22;
        r_200_9 = 8'd2;
`endif

        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_quotient", 32'(quotient), 32'd0);
        chk("reset_remainder", 32'(remainder), 32'd0);
        chk("reset_div_by_zero", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;

        launch("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        drain("d100_7");
        launch("d5_0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1);
        drain("d5_0");
        launch("d9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
        drain("d9_3");
        launch("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
        drain("d255_255");

        // start held high across two operations: accepts are WIDTH+3 apart.
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd255;
        divisor  = 8'd1;
        acc      = cyc + 1;
        sb.push_back('{8'd255, 8'd0, 1'b0, done_at(acc, 1'b0), "held_255_1"});
        @(negedge clk);
        dividend = 8'd3;
        divisor  = 8'd200;
        sb.push_back('{8'd0, 8'd3, 1'b0, done_at(acc + WIDTH + 3, 1'b0), "held_3_200"});
        repeat (WIDTH + 3) @(negedge clk);
        start = 1'b0;
        drain("held");

        // A start pulse during CALC is ignored.
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd9;
        acc      = cyc + 1;
        sb.push_back('{q_200_9, r_200_9, 1'b0, done_at(acc, 1'b0), "d200_9"});
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        @(negedge clk);
        start = 1'b0;
        drain("d200_9");

        // Asynchronous reset after CALC iteration 4 aborts without done.
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_quotient", 32'(quotient), 32'd0);
        chk("abort_remainder", 32'(remainder), 32'd0);
        chk("abort_div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        launch("d64_8", 8'd64, 8'd8, 8'd8, 8'd0, 1'b0);
        drain("d64_8");

`ifdef DIV_SIGNED_EN
        launch("s_m7_2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0);
        drain("s_m7_2");
        launch("s_7_m2", 8'd7, 8'hFE, 8'hFD, 8'h01, 1'b0);
        drain("s_7_m2");
        launch("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
        drain("s_m128_m1");
`endif

        repeat (3) @(negedge clk);
        chk("idle_busy_end", 32'(busy), 32'd0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
